register_file_mp: RTL and testbench

//  Parametrised multi-port MIPS register file for the pipelined core: NUM_READ

---
 rtl/register_file_mp.sv | 121 ++++++++++++
 tb/tb_register_file_mp.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file with two write ports, same-cycle write-to-read
// bypass, a per-register busy scoreboard and a post-reset clearing sequencer.
module register_file_mp #(
    parameter int SIZE       = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           ready,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           we0,
    input  logic [ADDR_WIDTH-1:0]          wa0,
    input  logic [DATA_WIDTH-1:0]          wd0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [DATA_WIDTH-1:0]          wd1,
    input  logic                           rsv_en,
    input  logic [ADDR_WIDTH-1:0]          rsv_addr
);

    localparam int IW = ADDR_WIDTH + 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic [DATA_WIDTH-1:0]   regs [SIZE];
    logic [SIZE-1:0]         busy_q;
    logic [ADDR_WIDTH-1:0]   rd_a;

    assign ready = (state_q == S_RUN);

    // State and clear-index registers; reset restarts the clearing sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: walk idx over every register, then enter RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == S_INIT) begin
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(SIZE - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    // Register array: cleared one entry per cycle in INIT, port 1 wins in RUN.
    // Per-entry decode keeps out-of-range addresses (non-power-of-2 SIZE) inert.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < SIZE; r++) begin
            if (rst) begin
                // hold contents; clearing is done by the INIT walk
            end else if (state_q == S_INIT) begin
                if (idx_q == IW'(r)) begin
                    regs[r] <= '0;
                end
            end else if (r != 0) begin
                if (we1 && wa1 == ADDR_WIDTH'(r)) begin
                    regs[r] <= wd1;
                end else if (we0 && wa0 == ADDR_WIDTH'(r)) begin
                    regs[r] <= wd0;
                end
            end
        end
    end

    // Busy scoreboard: reservation sets, any write clears, reservation wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else if (state_q == S_RUN) begin
            for (int unsigned r = 1; r < SIZE; r++) begin
                if (rsv_en && rsv_addr == ADDR_WIDTH'(r)) begin
                    busy_q[r] <= 1'b1;
                end else if ((we0 && wa0 == ADDR_WIDTH'(r)) ||
                             (we1 && wa1 == ADDR_WIDTH'(r))) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports with write bypass; busy is not bypassed.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_a    = '0;
        for (int unsigned p = 0; p < NUM_READ; p++) begin
            rd_a = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (state_q == S_RUN && rd_a != '0 && {1'b0, rd_a} < IW'(SIZE)) begin
                if (we1 && wa1 == rd_a) begin
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wd1;
                end else if (we0 && wa0 == rd_a) begin
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wd0;
                end else begin
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_a];
                end
                rd_busy[p] = busy_q[rd_a];
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard testbench for register_file_mp: a 32x32 two-read-port instance
// and a 24-entry three-read-port instance sharing write/reserve inputs.
module tb_register_file_mp;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready, ready2;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_busy;
    logic [3*AW-1:0] rd_addr2;
    logic [3*DW-1:0] rd_data2;
    logic [2:0]      rd_busy2;
    logic          we0, we1, rsv_en;
    logic [AW-1:0] wa0, wa1, rsv_addr;
    logic [DW-1:0] wd0, wd1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    register_file_mp #(.SIZE(32), .DATA_WIDTH(DW), .NUM_READ(2)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    register_file_mp #(.SIZE(24), .DATA_WIDTH(DW), .NUM_READ(3)) dut2 (
        .clk(clk), .rst(rst), .ready(ready2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    function automatic void push(string tag, logic [31:0] v);
        sb.push_back('{tag, v});
    endfunction

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] obs;
        idle();
        rd_addr  = {5'd6, 5'd5};
        rd_addr2 = '0;
        rst = 1'b1;
        align();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k == 20) begin
                we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hCAFEF00D;
                rsv_en = 1'b1; rsv_addr = 5'd6;
                push("init_rd_data0", 32'h0);
                push("init_rd_busy", 32'h0);
                @(negedge clk);
                obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
                if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
                obs = {30'b0, rd_busy}; e = sb.pop_front(); n_checks++;
                if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
            end
            align();
            idle();
            push($sformatf("ready_c%0d", k), 32'(k == 32));
            push($sformatf("ready2_c%0d", k), 32'(k >= 24));
            obs = {31'b0, ready}; e = sb.pop_front(); n_checks++;
            if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
            obs = {31'b0, ready2}; e = sb.pop_front(); n_checks++;
            if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            push($sformatf("clr_rd0_a%0d", a), 32'h0);
            push($sformatf("clr_rd1_a%0d", 31 - a), 32'h0);
            push($sformatf("clr_busy_a%0d", a), 32'h0);
            @(negedge clk);
            obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
            if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
            obs = rd_data[63:32]; e = sb.pop_front(); n_checks++;
            if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
            obs = {30'b0, rd_busy}; e = sb.pop_front(); n_checks++;
            if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        end
    endtask

    task automatic test_bypass();
        exp_t        e;
        logic [31:0] obs;
        align();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5};
        push("bypass_rd0", 32'hDEADBEEF);
        @(negedge clk);
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        idle();
        rd_addr = {5'd5, 5'd5};
        push("array_rd0", 32'hDEADBEEF);
        push("array_rd1", 32'hDEADBEEF);
        @(negedge clk);
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data[63:32]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
    endtask

    task automatic test_dual_write();
        exp_t        e;
        logic [31:0] obs;
        align();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        rd_addr = {5'd7, 5'd7};
        push("same_addr_bypass_rd0", 32'h22);
        push("same_addr_bypass_rd1", 32'h22);
        @(negedge clk);
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data[63:32]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        // port 0 to reg 8 while port 1 writes elsewhere: bypass from wd0
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h88;
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'hA0;
        rd_addr = {5'd8, 5'd7};
        push("same_addr_stored", 32'h22);
        push("wd0_bypass_rd1", 32'h88);
        @(negedge clk);
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data[63:32]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        idle();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFF;
        rd_addr = {5'd10, 5'd0};
        push("zero_bypass_rd0", 32'h0);
        push("reg10_rd1", 32'hA0);
        @(negedge clk);
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data[63:32]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        idle();
        rd_addr = {5'd8, 5'd0};
        push("zero_after_write_rd0", 32'h0);
        push("reg8_rd1", 32'h88);
        @(negedge clk);
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data[63:32]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
    endtask

    task automatic test_scoreboard();
        exp_t        e;
        logic [31:0] obs;
        align();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        rd_addr = {5'd9, 5'd9};
        push("busy9_same_cycle", 32'h0);
        @(negedge clk);
        obs = {31'b0, rd_busy[1]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        idle();
        push("busy9_after_rsv", 32'h1);
        @(negedge clk);
        obs = {31'b0, rd_busy[1]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99;
        push("busy9_during_write", 32'h1);
        push("rd9_write_bypass", 32'h99);
        @(negedge clk);
        obs = {31'b0, rd_busy[1]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data[63:32]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        idle();
        push("busy9_after_write", 32'h0);
        @(negedge clk);
        obs = {31'b0, rd_busy[1]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h77;
        align();
        idle();
        push("busy9_rsv_wins", 32'h1);
        push("rd9_after_tie", 32'h77);
        @(negedge clk);
        obs = {31'b0, rd_busy[1]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_addr = {5'd0, 5'd9};
        align();
        idle();
        push("busy0_never_set", 32'h0);
        push("busy9_unaffected", 32'h1);
        @(negedge clk);
        obs = {31'b0, rd_busy[1]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = {31'b0, rd_busy[0]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h9;
        align();
        idle();
        push("busy9_cleared_again", 32'h0);
        @(negedge clk);
        obs = {31'b0, rd_busy[0]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
    endtask

    task automatic test_reset_restart();
        exp_t        e;
        logic [31:0] obs;
        align();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234;
        rsv_en = 1'b1; rsv_addr = 5'd12;
        align();
        idle();
        rd_addr = {5'd12, 5'd3};
        push("reg3_before_rst", 32'h1234);
        push("busy12_before_rst", 32'h1);
        @(negedge clk);
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = {31'b0, rd_busy[1]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            align();
            push($sformatf("ready_mid_init_c%0d", k), 32'h0);
            obs = {31'b0, ready}; e = sb.pop_front(); n_checks++;
            if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        end
        rst = 1'b1;
        align();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            align();
            push($sformatf("ready_restart_c%0d", k), 32'(k == 32));
            obs = {31'b0, ready}; e = sb.pop_front(); n_checks++;
            if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        end
        push("reg3_after_rst", 32'h0);
        push("busy12_after_rst", 32'h0);
        @(negedge clk);
        obs = rd_data[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = {31'b0, rd_busy[1]}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
    endtask

    task automatic test_three_ports();
        exp_t        e;
        logic [31:0] obs;
        align();
        push("ready2_run", 32'h1);
        obs = {31'b0, ready2}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hA1;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hA2;
        align();
        we0 = 1'b1; wa0 = 5'd23; wd0 = 32'hA23;
        we1 = 1'b1; wa1 = 5'd30; wd1 = 32'hBAD;
        rsv_en = 1'b1; rsv_addr = 5'd30;
        align();
        idle();
        rd_addr2 = {5'd23, 5'd2, 5'd1};
        push("p3_rd0_reg1", 32'hA1);
        push("p3_rd1_reg2", 32'hA2);
        push("p3_rd2_reg23", 32'hA23);
        @(negedge clk);
        obs = rd_data2[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data2[63:32]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data2[95:64]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        rd_addr2 = {5'd23, 5'd30, 5'd30};
        push("p3_rd0_out_of_range", 32'h0);
        push("p3_busy_out_of_range", 32'h0);
        push("p3_rd2_reg23_again", 32'hA23);
        #2;
        obs = rd_data2[31:0]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = {29'b0, rd_busy2}; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
        obs = rd_data2[95:64]; e = sb.pop_front(); n_checks++;
        if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.tag, obs, e.val); end
    endtask

    initial begin
        rst = 1'b0;
        rd_addr = '0;
        rd_addr2 = '0;
        idle();
        test_reset();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_reset_restart();
        test_three_ports();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
